// File: rtl/stun_controller.sv
// stun_controller -- per-player stun manager for the momentumGO arena.
//
// On every bomb detonation each player is tested against a square blast
// window of half-width RADIUS around the bomb tile. A player that is hit is
// stunned for STUN_CYCLES clock cycles by its own countdown timer. Player
// movement logic gates each player's motion with that player's stunned bit.
//
// Optional feature macro: STUN_IMMUNITY_EN
//   When defined, a player passes through an IMMUNE state for IMMUNE_CYCLES
//   cycles after its stun ends. Hits are ignored while IMMUNE.
//   When undefined, STUNNED returns straight to IDLE.
//
// Ports:
//   clk         in   1                    system clock, rising edge
//   resetn      in   1                    asynchronous active-low reset
//   bomb_valid  in   1                    one-cycle detonation strobe
//   bomb_x      in   COORD_W              bomb tile X
//   bomb_y      in   COORD_W              bomb tile Y
//   player_x    in   NUM_PLAYERS*COORD_W  packed player X, player i at [i*COORD_W +: COORD_W]
//   player_y    in   NUM_PLAYERS*COORD_W  packed player Y, same packing
//   stunned     out  NUM_PLAYERS          bit i high while player i is stunned
//   stun_start  out  NUM_PLAYERS          one-cycle pulse when player i enters stun
//   busy        out  1                    OR of all stunned bits (registered)
module stun_controller #(
    parameter int NUM_PLAYERS   = 2,
    parameter int COORD_W       = 6,
    parameter int RADIUS        = 1,
    parameter int STUN_CYCLES   = 250000000,
    parameter int IMMUNE_CYCLES = 50000000
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           bomb_valid,
    input  logic [COORD_W-1:0]             bomb_x,
    input  logic [COORD_W-1:0]             bomb_y,
    input  logic [NUM_PLAYERS*COORD_W-1:0] player_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] player_y,
    output logic [NUM_PLAYERS-1:0]         stunned,
    output logic [NUM_PLAYERS-1:0]         stun_start,
    output logic                           busy
);

    localparam int CNT_MAX = (STUN_CYCLES > IMMUNE_CYCLES) ? STUN_CYCLES : IMMUNE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   STUN_LOAD = CNT_W'(STUN_CYCLES - 1);
    localparam logic [COORD_W:0]   RAD       = (COORD_W + 1)'(RADIUS);

`ifdef STUN_IMMUNITY_EN
    localparam logic [CNT_W-1:0]   IMMUNE_LOAD = CNT_W'(IMMUNE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STUNNED = 2'd1,
        ST_IMMUNE  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STUNNED = 2'd1
    } state_e;
`endif

    state_e                 state_q [NUM_PLAYERS];
    state_e                 state_d [NUM_PLAYERS];
    logic [CNT_W-1:0]       cnt_q   [NUM_PLAYERS];
    logic [CNT_W-1:0]       cnt_d   [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] stunned_q, stunned_d;
    logic [NUM_PLAYERS-1:0] start_q, start_d;
    logic                   busy_q;
    logic [NUM_PLAYERS-1:0] hit;

    // Distance is formed one bit wider than the coordinates so that the
    // grid edges never wrap (a player at 0 is far from a bomb at max).
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            hit[i] = bomb_valid
                  && (abs_diff(player_x[i*COORD_W +: COORD_W], bomb_x) <= RAD)
                  && (abs_diff(player_y[i*COORD_W +: COORD_W], bomb_y) <= RAD);
        end
    end

    // Hits are only honoured from IDLE, so a bomb landing on the cycle a
    // timer expires is dropped rather than restarting the stun.
    always_comb begin
        stunned_d = '0;
        start_d   = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (hit[i]) begin
                        state_d[i] = ST_STUNNED;
                        cnt_d[i]   = STUN_LOAD;
                        start_d[i] = 1'b1;
                    end
                end
                ST_STUNNED: begin
                    if (cnt_q[i] == '0) begin
`ifdef STUN_IMMUNITY_EN
                        state_d[i] = ST_IMMUNE;
                        cnt_d[i]   = IMMUNE_LOAD;
`else
                        state_d[i] = ST_IDLE;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
`ifdef STUN_IMMUNITY_EN
                ST_IMMUNE: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
`endif
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            stunned_d[i] = (state_d[i] == ST_STUNNED);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            stunned_q <= '0;
            start_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            stunned_q <= stunned_d;
            start_q   <= start_d;
            busy_q    <= |stunned_d;
        end
    end

    assign stunned    = stunned_q;
    assign stun_start = start_q;
    assign busy       = busy_q;

endmodule
